sram_like_slave: RTL

- Responder end of the team's SRAM-like request/response interface (en/wr/size/we/addr/wdata, addr_ok/data_ok/rdata).
- Accepts requests from a pipeline initiator (inst or data port) and keeps up to MAX_OUT requests outstanding.
- Performs each access on a backing synchronous RAM with 1-cycle read latency.
- Returns responses strictly in order, with programmable extra latency and verification throttles.

---
 rtl/sram_like_slave.sv | 112 +++++++++++
 1 files changed

// File: rtl/sram_like_slave.sv
// Responder end of the SRAM-like request/response interface: accepts up to MAX_OUT
// outstanding requests, drives a 1-cycle-latency backing RAM and answers strictly in order.
module sram_like_slave #(
    parameter int MAX_OUT    = 2,
    parameter int RESP_DELAY = 0,
    parameter int RAM_AW     = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sram_en,
    input  logic              sram_wr,
    input  logic [1:0]        sram_size,
    input  logic [3:0]        sram_we,
    input  logic [31:0]       sram_addr,
    input  logic [31:0]       sram_wdata,
    output logic              sram_addr_ok,
    output logic              sram_data_ok,
    output logic [31:0]       sram_rdata,
    input  logic              addr_stall,
    input  logic              data_stall,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [OW-1:0] MAX_C    = OW'(MAX_OUT);
    localparam logic [2:0]    DLY      = 3'(RESP_DELAY);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUT - 1);

    logic [OW-1:0] out_cnt;
    logic [OW-1:0] fifo_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [2:0]    dly_cnt;
    logic          vld_p0;
    logic          wr_p0;
    logic [31:0]   fifo_mem [MAX_OUT];
    logic          accept;
    logic          push;
    logic          pop;
    logic          head_vld;
    logic          unused_bits;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // sram_size is informational only; byte lanes come from sram_we
    assign unused_bits = &{1'b0, sram_size, sram_addr};

    assign accept       = resetn & sram_en & (out_cnt < MAX_C) & ~addr_stall;
    assign sram_addr_ok = accept;
    assign ram_en       = accept;
    assign ram_we       = sram_we & {4{sram_wr & accept}};
    assign ram_addr     = sram_addr[RAM_AW+1:2];
    assign ram_wdata    = sram_wdata;

    assign push         = vld_p0;
    assign head_vld     = (fifo_cnt != '0);
    assign pop          = head_vld & (dly_cnt == DLY) & ~data_stall;
    assign sram_data_ok = pop;
    assign sram_rdata   = pop ? fifo_mem[rd_ptr] : '0;

    // Stage p0: request accepted, RAM access in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) vld_p0 <= 1'b0;
        else         vld_p0 <= accept;
    end

    always_ff @(posedge clk) begin
        wr_p0 <= sram_wr;
    end

    // Response FIFO: RAM read data lands here the cycle after the access
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wr_p0 ? '0 : ram_rdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            out_cnt  <= '0;
            dly_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + OW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - OW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            case ({accept, pop})
                2'b10:   out_cnt <= out_cnt + OW'(1);
                2'b01:   out_cnt <= out_cnt - OW'(1);
                default: out_cnt <= out_cnt;
            endcase
            // A pop (or an empty FIFO) means the next head starts its wait from zero
            if (pop || !head_vld)  dly_cnt <= '0;
            else if (dly_cnt != DLY) dly_cnt <= dly_cnt + 3'd1;
        end
    end

    // out_cnt bounds the pipeline stage plus FIFO, so the FIFO can never overflow
    assert property (@(posedge clk) disable iff (!resetn) !(push && fifo_cnt == MAX_C));

endmodule
